// File: rtl/mips_pkg.sv
// Shared constants for the pipeline control blocks: register-file address width,
// debug FSM encodings and the hard-wired zero register.
package mips_pkg;

    localparam int NB_ADDR  = 5;
    localparam int REG_ZERO = 0;

    localparam logic [1:0] DBG_RUN  = 2'd0;
    localparam logic [1:0] DBG_HALT = 2'd1;
    localparam logic [1:0] DBG_STEP = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN  = DBG_RUN,
        ST_HALT = DBG_HALT,
        ST_STEP = DBG_STEP
    } dbg_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment,
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int NB_CNT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [NB_CNT-1:0] o_cnt
);

    logic [NB_CNT-1:0] r_cnt;

    // Count qualifying cycles, holding at the maximum value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + NB_CNT'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: load-use and ID-branch operand hazard detection,
// IF/ID flush, PC/IF-ID stall, debug run/halt/step gating of all pipeline
// enables, and stall/flush cycle counters.
module hazard_ctrl_unit
    import mips_pkg::*;
#(
    parameter int NB_ADDR      = mips_pkg::NB_ADDR,
    parameter int NB_CNT       = 16,
    parameter int BRANCH_IN_ID = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_jump,
    input  logic               i_branch_taken,
    input  logic               i_branch_id,
    input  logic               i_uses_rt_id,
    input  logic [NB_ADDR-1:0] i_rs_id,
    input  logic [NB_ADDR-1:0] i_rt_id,
    input  logic [NB_ADDR-1:0] i_wr_addr_ex,
    input  logic               i_reg_write_ex,
    input  logic               i_mem_read_ex,
    input  logic [NB_ADDR-1:0] i_wr_addr_mem,
    input  logic               i_mem_read_mem,
    input  logic               i_halt_req,
    input  logic               i_step_req,
    input  logic               i_resume,
    input  logic               i_cnt_clr,
    output logic               o_stall,
    output logic               o_flush,
    output logic               o_pipe_en,
    output logic               o_halted,
    output logic [NB_CNT-1:0]  o_stall_cnt,
    output logic [NB_CNT-1:0]  o_flush_cnt
);

    localparam logic [NB_ADDR-1:0] ZERO_ADDR = NB_ADDR'(REG_ZERO);

    dbg_state_e r_state;
    dbg_state_e w_next;

    logic w_rt_used;
    logic w_match_ex;
    logic w_match_mem;
    logic w_load_use;
    logic w_branch_hz;
    logic w_hazard;

    // Branches compare rs and rt in ID, so rt counts as a source for them.
    assign w_rt_used   = i_uses_rt_id | i_branch_id;
    assign w_match_ex  = (i_wr_addr_ex != ZERO_ADDR) &&
                         ((i_wr_addr_ex == i_rs_id) || (w_rt_used && (i_wr_addr_ex == i_rt_id)));
    assign w_match_mem = (i_wr_addr_mem != ZERO_ADDR) &&
                         ((i_wr_addr_mem == i_rs_id) || (w_rt_used && (i_wr_addr_mem == i_rt_id)));

    assign w_load_use  = i_mem_read_ex & w_match_ex;

    generate
        if (BRANCH_IN_ID != 0) begin : g_branch_id
            // Any EX writer, or a load still in MEM, has not produced the compare operand yet.
            assign w_branch_hz = i_branch_id &
                                 ((i_reg_write_ex & w_match_ex) | (i_mem_read_mem & w_match_mem));
        end else begin : g_branch_ex
            assign w_branch_hz = 1'b0;
        end
    endgenerate

    assign w_hazard  = w_load_use | w_branch_hz;

    assign o_pipe_en = (r_state != ST_HALT);
    assign o_halted  = (r_state == ST_HALT);
    assign o_stall   = w_hazard & o_pipe_en;
    // A stalled branch waits for valid operands before it may redirect fetch.
    assign o_flush   = (i_jump | i_branch_taken) & ~w_hazard & o_pipe_en;

    // Debug FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_RUN;
        else       r_state <= w_next;
    end

    // Debug FSM next state; resume outranks step, and STEP always lasts one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RUN:  if (i_halt_req) w_next = ST_HALT;
            ST_HALT: begin
                if (i_resume)        w_next = ST_RUN;
                else if (i_step_req) w_next = ST_STEP;
            end
            ST_STEP: w_next = ST_HALT;
            default: w_next = ST_RUN;
        endcase
    end

    sat_counter #(.NB_CNT(NB_CNT)) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (o_stall),
        .o_cnt (o_stall_cnt)
    );

    sat_counter #(.NB_CNT(NB_CNT)) u_flush_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (o_flush),
        .o_cnt (o_flush_cnt)
    );

endmodule
